// File: rtl/conversor_bcd_sequencial_if.sv
// Handshake and result bundle between a value source and the sequential BCD converter.
// The master side issues start requests; the slave side (the converter) returns the digits.
interface conversor_bcd_sequencial_if #(
    parameter int LARGURA = 32
);
    logic               iniciar;
    logic [LARGURA-1:0] entrada;
    logic               ocupado;
    logic               pronto;
    logic               sinal;
    logic [3:0]         milhar;
    logic [3:0]         centena;
    logic [3:0]         dezena;
    logic [3:0]         unidade;

    modport master (
        output iniciar, entrada,
        input  ocupado, pronto, sinal, milhar, centena, dezena, unidade
    );

    modport slave (
        input  iniciar, entrada,
        output ocupado, pronto, sinal, milhar, centena, dezena, unidade
    );
endinterface

// File: rtl/conversor_bcd_sequencial.sv
// Signed binary to 4-digit BCD via double dabble, one bit per cycle, fixed 15-cycle latency.
// Values outside -9999..9999 are shown as four dashes.
module conversor_bcd_sequencial #(
    parameter int LARGURA       = 32,
    parameter bit SUPRIME_ZEROS = 1'b1
) (
    input logic                       clock,
    input logic                       reset,
    conversor_bcd_sequencial_if.slave bus
);
    localparam logic [3:0] BRANCO     = 4'b1010;
    localparam logic [3:0] TRACO      = 4'b1111;
    localparam logic [3:0] ZERO_RESET = SUPRIME_ZEROS ? BRANCO : 4'b0000;
    localparam logic signed [LARGURA-1:0] LIMITE_POS = LARGURA'(9999);
    localparam logic signed [LARGURA-1:0] LIMITE_NEG = -LIMITE_POS;

    typedef enum logic [1:0] {OCIOSO, DESLOCA, FIM} estado_t;

    estado_t     estado;
    estado_t     proximo;
    logic        aceita;

    logic        neg;
    logic        excesso;
    logic [13:0] mag;
    logic [15:0] bcd;
    logic [3:0]  contador;

    logic        entrada_neg;
    logic        entrada_excesso;
    logic [13:0] entrada_mag;
    logic [15:0] bcd_ajustado;
    logic [3:0]  dig_m;
    logic [3:0]  dig_c;
    logic [3:0]  dig_d;

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        proximo = estado;
        aceita  = 1'b0;
        unique case (estado)
            OCIOSO: begin
                if (bus.iniciar) begin
                    aceita  = 1'b1;
                    proximo = DESLOCA;
                end
            end
            DESLOCA: begin
                if (contador == 4'd13) begin
                    proximo = FIM;
                end
            end
            FIM:     proximo = OCIOSO;
            default: proximo = OCIOSO;
        endcase
    end

    // Only the low 14 bits of |entrada| matter once the range check passes.
    always_comb begin
        entrada_neg     = bus.entrada[LARGURA-1];
        entrada_excesso = ($signed(bus.entrada) > LIMITE_POS) ||
                          ($signed(bus.entrada) < LIMITE_NEG);
        if (entrada_excesso) begin
            entrada_mag = '0;
        end else if (entrada_neg) begin
            entrada_mag = ~bus.entrada[13:0] + 14'd1;
        end else begin
            entrada_mag = bus.entrada[13:0];
        end
    end

    always_comb begin
        bcd_ajustado = bcd;
        for (int i = 0; i < 4; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                bcd_ajustado[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    // Leading-zero blanking walks down from milhar and stops at the first nonzero digit.
    always_comb begin
        dig_m = bcd[15:12];
        dig_c = bcd[11:8];
        dig_d = bcd[7:4];
        if (SUPRIME_ZEROS && bcd[15:12] == 4'd0) begin
            dig_m = BRANCO;
            if (bcd[11:8] == 4'd0) begin
                dig_c = BRANCO;
                if (bcd[7:4] == 4'd0) begin
                    dig_d = BRANCO;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado <= OCIOSO;
        end else begin
            estado <= proximo;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            neg      <= 1'b0;
            excesso  <= 1'b0;
            mag      <= '0;
            bcd      <= '0;
            contador <= '0;
        end else if (aceita) begin
            neg      <= entrada_neg;
            excesso  <= entrada_excesso;
            mag      <= entrada_mag;
            bcd      <= '0;
            contador <= '0;
        end else if (estado == DESLOCA) begin
            bcd      <= {bcd_ajustado[14:0], mag[13]};
            mag      <= {mag[12:0], 1'b0};
            contador <= contador + 4'd1;
        end
    end

    // Result registers change only in FIM, so partial scratch values never reach the outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus.ocupado <= 1'b0;
            bus.pronto  <= 1'b0;
            bus.sinal   <= 1'b0;
            bus.milhar  <= ZERO_RESET;
            bus.centena <= ZERO_RESET;
            bus.dezena  <= ZERO_RESET;
            bus.unidade <= 4'd0;
        end else begin
            bus.pronto <= (estado == FIM);
            if (aceita) begin
                bus.ocupado <= 1'b1;
            end else if (estado == FIM) begin
                bus.ocupado <= 1'b0;
            end
            if (estado == FIM) begin
                if (excesso) begin
                    bus.sinal   <= 1'b0;
                    bus.milhar  <= TRACO;
                    bus.centena <= TRACO;
                    bus.dezena  <= TRACO;
                    bus.unidade <= TRACO;
                end else begin
                    bus.sinal   <= neg;
                    bus.milhar  <= dig_m;
                    bus.centena <= dig_c;
                    bus.dezena  <= dig_d;
                    bus.unidade <= bcd[3:0];
                end
            end
        end
    end
endmodule

// File: tb/tb_conversor_bcd_sequencial.sv
// Scoreboard bench: the driver queues expected results at each accepting edge and a monitor
// pops and compares them whenever pronto is seen, for a blanking and a non-blanking instance.
module tb_conversor_bcd_sequencial;
    typedef struct {
        logic [16:0] res;
        int          acc;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t fila1[$];
    exp_t fila0[$];

    conversor_bcd_sequencial_if #(.LARGURA(32)) bus1 ();
    conversor_bcd_sequencial_if #(.LARGURA(32)) bus0 ();

    conversor_bcd_sequencial #(.LARGURA(32), .SUPRIME_ZEROS(1'b1)) dut1 (
        .clock (clock),
        .reset (reset),
        .bus   (bus1)
    );

    conversor_bcd_sequencial #(.LARGURA(32), .SUPRIME_ZEROS(1'b0)) dut0 (
        .clock (clock),
        .reset (reset),
        .bus   (bus0)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Reference: decimal digits by division, {sinal, milhar, centena, dezena, unidade}.
    function automatic logic [16:0] model(input logic signed [31:0] v, input bit sz);
        longint     a;
        logic [3:0] m, c, d, u;
        logic       s;
        if (v > 9999 || v < -9999) return 17'h0FFFF;
        s = (v < 0);
        a = s ? -longint'(v) : longint'(v);
        m = 4'(a / 1000);
        c = 4'((a / 100) % 10);
        d = 4'((a / 10) % 10);
        u = 4'(a % 10);
        if (sz && m == 4'd0) begin
            m = 4'hA;
            if (c == 4'd0) begin
                c = 4'hA;
                if (d == 4'd0) d = 4'hA;
            end
        end
        return {s, m, c, d, u};
    endfunction

    task automatic drive(input logic ini, input logic signed [31:0] v);
        bus1.iniciar = ini;
        bus1.entrada = v;
        bus0.iniciar = ini;
        bus0.entrada = v;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_ocupado1"}, bus1.ocupado, 0);
        check({tag, "_pronto1"},  bus1.pronto, 0);
        check({tag, "_saida1"},   {bus1.sinal, bus1.milhar, bus1.centena, bus1.dezena, bus1.unidade}, 17'h0AAA0);
        check({tag, "_ocupado0"}, bus0.ocupado, 0);
        check({tag, "_pronto0"},  bus0.pronto, 0);
        check({tag, "_saida0"},   {bus0.sinal, bus0.milhar, bus0.centena, bus0.dezena, bus0.unidade}, 17'h00000);
    endtask

    // One full conversion slot: accepting edge E0 plus E1..E15.
    task automatic run_conv(input logic signed [31:0] v, input logic [16:0] exp1, input logic [16:0] exp0,
                            input bit use_model, input bit hold, input bit chk_busy, input int ign_at);
        exp_t e;
        @(negedge clock);
        drive(1'b1, v);
        @(posedge clock);
        #1;
        e.acc = cyc;
        e.res = use_model ? model(v, 1'b1) : exp1;
        fila1.push_back(e);
        e.res = use_model ? model(v, 1'b0) : exp0;
        fila0.push_back(e);
        if (chk_busy) check("ocupado_e0", bus1.ocupado, 1);
        for (int k = 1; k <= 15; k++) begin
            @(negedge clock);
            if (k == ign_at) drive(1'b1, 32'sd42);
            else             drive(hold, v);
            @(posedge clock);
            #1;
            if (chk_busy) check("ocupado", bus1.ocupado, (k < 15) ? 1 : 0);
        end
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (bus1.pronto === 1'b1) begin
            check("pronto1_tem_entrada", (fila1.size() > 0) ? 1 : 0, 1);
            if (fila1.size() > 0) begin
                e = fila1.pop_front();
                check("resultado1", {bus1.sinal, bus1.milhar, bus1.centena, bus1.dezena, bus1.unidade}, e.res);
                check("latencia1", cyc, e.acc + 15);
            end
        end
        if (bus0.pronto === 1'b1) begin
            check("pronto0_tem_entrada", (fila0.size() > 0) ? 1 : 0, 1);
            if (fila0.size() > 0) begin
                e = fila0.pop_front();
                check("resultado0", {bus0.sinal, bus0.milhar, bus0.centena, bus0.dezena, bus0.unidade}, e.res);
                check("latencia0", cyc, e.acc + 15);
            end
        end
    end

    initial begin
        drive(1'b0, 32'sd0);
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check_reset("reset_inicial");
        @(negedge clock);
        reset = 1'b0;

        run_conv(32'sd1234, 17'h01234, 17'h01234, 1'b0, 1'b0, 1'b1, 0);

        // Abort mid-DESLOCA: nothing is queued, so any later pronto is flagged by the monitor.
        @(negedge clock);
        drive(1'b1, 32'sd5678);
        @(posedge clock);
        #1;
        drive(1'b0, 32'sd5678);
        repeat (5) @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        check_reset("reset_desloca");
        @(negedge clock);
        reset = 1'b0;
        repeat (20) @(posedge clock);
        #1;
        check("fila1_apos_abort", fila1.size(), 0);

        run_conv(-32'sd57,          17'h1AA57, 17'h10057, 1'b0, 1'b0, 1'b0, 0);
        run_conv(32'sd0,            17'h0AAA0, 17'h00000, 1'b0, 1'b0, 1'b1, 0);
        run_conv(32'sd9999,         17'h09999, 17'h09999, 1'b0, 1'b0, 1'b0, 0);
        run_conv(-32'sd9999,        17'h19999, 17'h19999, 1'b0, 1'b0, 1'b0, 0);
        run_conv(32'sd105,          17'h0A105, 17'h00105, 1'b0, 1'b0, 1'b0, 0);
        run_conv(32'sd10000,        17'h0FFFF, 17'h0FFFF, 1'b0, 1'b0, 1'b1, 0);
        run_conv(-32'sd10000,       17'h0FFFF, 17'h0FFFF, 1'b0, 1'b0, 1'b0, 0);
        run_conv(32'sh8000_0000,    17'h0FFFF, 17'h0FFFF, 1'b0, 1'b0, 1'b0, 0);
        run_conv(32'sd1234,         17'h01234, 17'h01234, 1'b0, 1'b0, 1'b1, 5);
        run_conv(32'sd42,           17'h0AA42, 17'h00042, 1'b0, 1'b0, 1'b0, 0);
        run_conv(32'sd7,            17'h0AAA7, 17'h00007, 1'b0, 1'b0, 1'b0, 0);

        // Back-to-back sweep with iniciar held high; every result goes through the model.
        for (int v = -9999; v <= 9999; v += 9) begin
            run_conv(v, 17'h0, 17'h0, 1'b1, 1'b1, 1'b0, 0);
        end
        @(negedge clock);
        drive(1'b0, 32'sd0);

        repeat (20) @(posedge clock);
        #1;
        check("fila1_vazia", fila1.size(), 0);
        check("fila0_vazia", fila0.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
